// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and timing defaults (tx and rx)
package uart_pkg;

  // Transmit FSM states; PARITY is only reachable when UART_TX_PARITY_EN is defined
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  // 100 MHz system clock / 9600 baud
  localparam int unsigned CLKS_PER_BIT_DEFAULT = 10416;

endpackage

// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - byte handshake and serial/status signals of the UART transmitter
interface uart_tx_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 tx;
  logic                 tx_busy;
  logic                 tx_done;

  // Byte source (FIFO side / testbench)
  modport master (
    output tx_data, tx_valid,
    input  tx_ready, tx, tx_busy, tx_done
  );

  // Transmitter
  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, tx, tx_busy, tx_done
  );
endinterface

// File: rtl/uart_tx_baud_counter.sv
// rtl/uart_tx_baud_counter.sv - per-bit wait counter producing a bit_end strobe
module uart_tx_baud_counter
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic bit_end_o
);
  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign bit_end_o = enable_i && (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

  // Count 0..CLKS_PER_BIT-1 while enabled; a clear (frame accept) restarts the bit
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = bit_end_o ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter, start/data/stop framing; optional even parity via UART_TX_PARITY_EN
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  uart_tx_if.slave bus
);
  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [3:0]           bit_idx_q, bit_idx_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;
  logic                 accept;
  logic                 bit_end;
`ifdef UART_TX_PARITY_EN
  logic                 par_q, par_d;
`endif

  assign bus.tx_ready = (state_q == IDLE);
  assign bus.tx_busy  = (state_q != IDLE);
  assign bus.tx       = tx_q;
  assign bus.tx_done  = done_q;
  assign accept       = bus.tx_valid && (state_q == IDLE);

  uart_tx_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clear_i  (accept),
    .enable_i (state_q != IDLE),
    .bit_end_o(bit_end)
  );

  // State, shift register and bit index advance; tx is registered from next state so it tracks state_q
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_idx_q <= '0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  // Next state plus the datapath it drags along (latch on accept, shift and count at bit ends)
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_idx_d = bit_idx_q;
`ifdef UART_TX_PARITY_EN
    par_d     = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = START;
          shreg_d   = bus.tx_data;
          bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
          par_d     = ^bus.tx_data;
`endif
        end
      end
      START: begin
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          if (bit_idx_q == 4'(DATA_BITS - 1)) begin
            bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d   = PARITY;
`else
            state_d   = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (bit_idx_q == 4'(STOP_BITS - 1)) begin
            bit_idx_d = '0;
            state_d   = IDLE;
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level for the upcoming cycle and the frame-complete pulse
  always_comb begin
    tx_d   = 1'b1;
    done_d = (state_q == STOP) && (state_d == IDLE);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = par_q;
`endif
      default: tx_d = 1'b1;
    endcase
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed self-checking bench for uart_tx (CLKS_PER_BIT=4)
module tb_uart_tx;
  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic clk = 1'b0;
  logic rst_ni;
  int   n_checks = 0;
  int   n_errors = 0;

  uart_tx_if #(.DATA_BITS(8)) bus ();

  uart_tx #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (8),
    .STOP_BITS   (1)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_ni),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected line levels, LSB = first bit on the wire
  function automatic logic [15:0] frame(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
    return {5'b0, 1'b1, ^b, b, 1'b0};
`else
    return {6'b0, 1'b1, b, 1'b0};
`endif
  endfunction

  // Called at a negedge in IDLE; returns at the negedge of frame cycle 0
  task automatic send(input logic [7:0] b, input bit keep_valid);
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    check("send_ready", bus.tx_ready, 1'b1);
    @(negedge clk);
    if (!keep_valid) bus.tx_valid = 1'b0;
  endtask

  // Checks every cycle of one frame, then the tx_done cycle; returns at that negedge
  task automatic check_frame(input logic [15:0] bits, input string tag,
                             input int poke_at, input logic [7:0] poke_val);
    int ready_seen = 0;
    int done_seen  = 0;
    int busy_low   = 0;
    for (int c = 0; c < FRAME_BITS * CPB; c++) begin
      if (c == poke_at) bus.tx_data = poke_val;
      check($sformatf("%s_tx_c%0d", tag, c), bus.tx, bits[c / CPB]);
      if (bus.tx_ready) ready_seen++;
      if (bus.tx_done) done_seen++;
      if (!bus.tx_busy) busy_low++;
      @(negedge clk);
    end
    check({tag, "_ready_in_frame"}, ready_seen, 0);
    check({tag, "_done_early"}, done_seen, 0);
    check({tag, "_busy_low_in_frame"}, busy_low, 0);
    check({tag, "_done_end"}, bus.tx_done, 1'b1);
    check({tag, "_ready_end"}, bus.tx_ready, 1'b1);
    check({tag, "_busy_end"}, bus.tx_busy, 1'b0);
    check({tag, "_tx_end"}, bus.tx, 1'b1);
  endtask

  initial begin
    rst_ni       = 1'b0;
    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_tx_async", bus.tx, 1'b1);
    rst_ni = 1'b1;

    // Reset only: {tx, busy, ready, done} stays idle
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check($sformatf("idle_c%0d", i), {bus.tx, bus.tx_busy, bus.tx_ready, bus.tx_done}, 4'b1010);
    end

    // Single frame 8'hA5: 0,1,0,1,0,0,1,0,1,1
    send(8'hA5, 1'b0);
    check_frame(16'h034A, "a5", -1, 8'h00);
    @(negedge clk);
    check("a5_done_one_cycle", bus.tx_done, 1'b0);

    // Back-to-back 8'h00 then 8'hFF with tx_valid held
    send(8'h00, 1'b1);
    bus.tx_data = 8'hFF;
    check_frame(frame(8'h00), "b2b0", -1, 8'h00);
    @(negedge clk);
    bus.tx_valid = 1'b0;
    check("b2b_start_after_done", bus.tx, 1'b0);
    check_frame(frame(8'hFF), "b2b1", -1, 8'h00);
    @(negedge clk);
    check("b2b_done_one_cycle", bus.tx_done, 1'b0);

    // Reset at frame cycle 13 (bit d2 of 8'hAA is 0 on the line)
    send(8'hAA, 1'b0);
    repeat (13) @(negedge clk);
    check("rst_pre_tx", bus.tx, 1'b0);
    rst_ni = 1'b0;
    #1;
    check("rst_mid_tx", bus.tx, 1'b1);
    check("rst_mid_busy", bus.tx_busy, 1'b0);
    check("rst_mid_ready", bus.tx_ready, 1'b1);
    @(negedge clk);
    check("rst_mid_done", bus.tx_done, 1'b0);
    rst_ni = 1'b1;
    @(negedge clk);
    check("rst_after_done", bus.tx_done, 1'b0);
    send(8'h3C, 1'b0);
    check_frame(16'h0278, "3c", -1, 8'h00);
    @(negedge clk);

    // tx_data changed mid-DATA must not affect the frame
    send(8'hC3, 1'b0);
    check_frame(frame(8'hC3), "hold", 10, 8'h3C);
    @(negedge clk);

    // 8'h07: parity bit 1 when enabled; 44 vs 40 cycle frame
    send(8'h07, 1'b0);
`ifdef UART_TX_PARITY_EN
    check_frame(16'h060E, "par07", -1, 8'h00);
`else
    check_frame(16'h020E, "par07", -1, 8'h00);
`endif
    @(negedge clk);
    check("par07_done_one_cycle", bus.tx_done, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter that serialises bytes onto a single `tx` line in 8N1-style frames: start bit, data bits LSB first, stop bit(s). It is the transmit-side counterpart of the existing UART receiver and uses the same per-bit wait-count timing. It sits downstream of the sync FIFO: it pops one byte per frame through a valid/ready handshake and drives the board TX pin. Status outputs are available for LEDs and the top level.

Parameters:
- CLKS_PER_BIT, 10416, clk cycles per bit (100 MHz / 9600 baud); counter width is $clog2(CLKS_PER_BIT).
- DATA_BITS, 8, data bits per frame (5..8).
- STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- tx_data  in  DATA_BITS  byte to send; sampled only on accept.
- tx_valid  in  1  tx_data is valid (FIFO not empty).
- tx_ready  out  1  high only in IDLE; accept = tx_valid & tx_ready (acts as the FIFO rd_en).
- tx  out  1  serial line; idles high; registered.
- tx_busy  out  1  high from the cycle after accept until the frame ends.
- tx_done  out  1  one-cycle pulse when the frame completes.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, tx=1, tx_busy=0, tx_done=0, tx_ready=1 after release.
  - Bit counter, baud counter and shift register clear to 0.
- FSM states: IDLE, START, DATA, [PARITY], STOP.
  - IDLE: tx=1. On accept, latch tx_data into the shift register, clear the baud counter, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: tx=shreg[0] for CLKS_PER_BIT cycles per bit. Shift right at each bit end. After DATA_BITS bits go to STOP (or PARITY when enabled).
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles, then IDLE.
- Latency: accept at edge k drives tx=0 from edge k+1. Every bit lasts exactly CLKS_PER_BIT cycles.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1; bit_end = (cnt==CLKS_PER_BIT-1).
  - Wraps to 0 on bit_end and is cleared on accept.
- Frame end: on the last STOP cycle's edge, state goes to IDLE, tx_done=1 for one cycle and tx_busy=0.
  - tx_ready is high in that same IDLE cycle, so a back-to-back frame starts with zero idle bits.
- tx_data/tx_valid changes while not in IDLE are ignored. tx_valid may drop without an accept; no requirement on the source.
- Reset asserted mid-frame: tx returns to 1 immediately and the partial frame is abandoned. No tx_done is generated.
- Simultaneous frame end and tx_valid=1: no accept that cycle (tx_ready was low). Accept happens on the next edge, in IDLE.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. tx = XOR of the latched data bits (even parity) for CLKS_PER_BIT cycles. Frame length becomes (2+DATA_BITS+STOP_BITS)*CLKS_PER_BIT.
- Undefined: no PARITY state and no parity logic. Frame length is (1+DATA_BITS+STOP_BITS)*CLKS_PER_BIT.

Decomposition:
- Package uart_pkg:
  - state enum/localparams: IDLE=3'd0, START=3'd1, DATA=3'd2, PARITY=3'd3, STOP=3'd4;
  - default CLKS_PER_BIT, shared with the receiver.
- One sub-module, uart_tx_baud_counter: parameter CLKS_PER_BIT; inputs clk, rst, clear, enable; output bit_end.
- FSM, bit index and shift register stay in uart_tx.

Test Plan (CLKS_PER_BIT=4 in simulation):
- Reset only → tx=1, tx_busy=0, tx_ready=1, tx_done=0 for 50 cycles.
- Send 8'hA5 → tx sequence, 4 cycles per bit: 0,1,0,1,0,0,1,0,1,1. tx_done pulses exactly 40 cycles after accept.
- Two bytes 8'h00 then 8'hFF, tx_valid held high → second start bit begins the cycle after tx_done. There is no extra idle bit, and tx_ready pulses exactly once per frame.
- Assert rst at cycle 13 of a frame → tx=1 asynchronously and the FSM returns to IDLE. A following 8'h3C frame transmits correctly.
- Change tx_data during the DATA state → the transmitted bits still match the byte latched at accept.
- With UART_TX_PARITY_EN, send 8'h07 → parity bit 1 sent after the 8 data bits. Frame is 44 cycles; without the macro it is 40 cycles.
